// File: rtl/ofifo_pkg.sv
// Shared defaults and helpers for the output FIFO and its lanes.
package ofifo_pkg;

    localparam int COL_DEF         = 8;
    localparam int PSUM_BW_DEF     = 16;
    localparam int OFIFO_DEPTH_DEF = 64;

    // One extra pointer bit separates "full" from "empty" when the index bits match.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Bit offset of lane j inside a packed multi-lane bus.
    function automatic int lane_lsb(input int j, input int bw);
        return j * bw;
    endfunction

endpackage

// File: rtl/ofifo_fifo_lane.sv
// Single-lane first-word-fall-through FIFO.
// The lane accepts a write on a full lane only when a pop happens in the same
// cycle. A write dropped for lack of room sets a sticky overflow flag.
module fifo_lane
    import ofifo_pkg::*;
#(
    parameter int psum_bw = PSUM_BW_DEF,
    parameter int depth   = OFIFO_DEPTH_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr,
    input  logic               rd,
    input  logic [psum_bw-1:0] in,
    output logic [psum_bw-1:0] out,
    output logic               empty,
    output logic               full,
    output logic               ovf
);

    localparam int PTR_W = ptr_w(depth);
    localparam int AW    = PTR_W - 1;

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic               ovf_q, ovf_d;
    logic               wr_en;
    logic               pop;
    logic [psum_bw-1:0] mem_q [depth];

    // Flags, accept decision and next pointer values.
    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop      = rd & ~empty;
        wr_en    = wr & (~full | pop);
        wr_ptr_d = wr_en ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d = pop   ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        ovf_d    = ovf_q | (wr & full & ~pop);
        out      = mem_q[rd_ptr_q[AW-1:0]];
        ovf      = ovf_q;
    end

    // Pointer and overflow registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is written in place; it is never cleared, only the pointers are.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            mem_q[wr_ptr_q[AW-1:0]] <= in;
        end
    end

endmodule

// File: rtl/ofifo.sv
// Output collector for the MAC array's south edge: one FWFT lane per column,
// whole rows released only when every lane holds a word.
module ofifo
    import ofifo_pkg::*;
#(
    parameter int col     = COL_DEF,
    parameter int psum_bw = PSUM_BW_DEF,
    parameter int depth   = OFIFO_DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [psum_bw*col-1:0] in,
    input  logic [col-1:0]         wr,
    input  logic                   rd,
    output logic [psum_bw*col-1:0] out,
    output logic                   o_valid,
    output logic                   o_full,
    output logic                   o_ready,
    output logic                   o_ovf
);

    logic [col-1:0]         lane_empty;
    logic [col-1:0]         lane_full;
    logic [col-1:0]         lane_ovf;
    logic [psum_bw*col-1:0] lane_out;
    logic                   pop;

    for (genvar j = 0; j < col; j++) begin : g_lane
        fifo_lane #(
            .psum_bw (psum_bw),
            .depth   (depth)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .wr    (wr[j]),
            .rd    (pop),
            .in    (in[lane_lsb(j, psum_bw) +: psum_bw]),
            .out   (lane_out[lane_lsb(j, psum_bw) +: psum_bw]),
            .empty (lane_empty[j]),
            .full  (lane_full[j]),
            .ovf   (lane_ovf[j])
        );
    end

    // Row-level flags and gated pop, all derived from registered lane state.
    always_comb begin
        o_valid = &(~lane_empty);
        o_full  = |lane_full;
        o_ready = ~o_full;
        o_ovf   = |lane_ovf;
        pop     = rd & o_valid;
        out     = o_valid ? lane_out : '0;
    end

endmodule

// File: tb/tb_ofifo.sv
module tb_ofifo;

    localparam int COL   = 8;
    localparam int BW    = 16;
    localparam int DEPTH = 64;

    logic             clk = 1'b0;
    logic             reset;
    logic [BW*COL-1:0] in;
    logic [COL-1:0]   wr;
    logic             rd;
    logic [BW*COL-1:0] out;
    logic             o_valid, o_full, o_ready, o_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: one queue of words per lane plus the sticky overflow.
    logic [BW-1:0] mq [COL][$];
    logic          m_ovf;
    int            wcnt [COL];

    always #5 clk = ~clk;

    ofifo #(.col(COL), .psum_bw(BW), .depth(DEPTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .in      (in),
        .wr      (wr),
        .rd      (rd),
        .out     (out),
        .o_valid (o_valid),
        .o_full  (o_full),
        .o_ready (o_ready),
        .o_ovf   (o_ovf)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic m_valid();
        for (int j = 0; j < COL; j++)
            if (mq[j].size() == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic m_full();
        for (int j = 0; j < COL; j++)
            if (mq[j].size() == DEPTH) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [BW*COL-1:0] m_out();
        logic [BW*COL-1:0] r = '0;
        if (m_valid())
            for (int j = 0; j < COL; j++) r[j*BW +: BW] = mq[j][0];
        return r;
    endfunction

    function automatic logic [BW*COL-1:0] rand_row();
        logic [BW*COL-1:0] r;
        for (int j = 0; j < COL; j++) r[j*BW +: BW] = BW'($urandom);
        return r;
    endfunction

    // Apply one cycle of inputs, advance the model, compare all outputs.
    task automatic step(input logic r_rst, input logic [COL-1:0] w,
                        input logic [BW*COL-1:0] d, input logic r_rd);
        logic pv, pop;
        logic [COL-1:0] lfull;
        reset = r_rst; wr = w; in = d; rd = r_rd;
        @(posedge clk);
        if (r_rst) begin
            for (int j = 0; j < COL; j++) mq[j].delete();
            m_ovf = 1'b0;
        end else begin
            pv  = m_valid();
            pop = r_rd & pv;
            for (int j = 0; j < COL; j++) lfull[j] = (mq[j].size() == DEPTH);
            for (int j = 0; j < COL; j++) begin
                if (pop) void'(mq[j].pop_front());
                if (w[j]) begin
                    if (!lfull[j] || pop) begin
                        mq[j].push_back(d[j*BW +: BW]);
                        wcnt[j]++;
                    end else m_ovf = 1'b1;
                end
            end
        end
        #1;
        chk("out", 128'(out), 128'(m_out()));
        chk("flags", 128'({o_valid, o_full, o_ready, o_ovf}),
            128'({m_valid(), m_full(), ~m_full(), m_ovf}));
    endtask

    task automatic do_reset();
        step(1'b1, '0, '0, 1'b0);
        for (int j = 0; j < COL; j++) wcnt[j] = 0;
    endtask

    initial begin
        logic [COL-1:0]    mask;
        logic [BW*COL-1:0] row;
        logic [BW*COL-1:0] exp_row;

        reset = 1'b1; wr = '0; in = '0; rd = 1'b0; m_ovf = 1'b0;
        for (int j = 0; j < COL; j++) wcnt[j] = 0;

        // Reset then idle with stray rd pulses.
        do_reset();
        do_reset();
        chk("rst_out", 128'(out), 128'(0));
        chk("rst_flags", 128'({o_valid, o_full, o_ready, o_ovf}), 128'(4'b0010));
        for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b1);
        chk("idle_rd_valid", 128'(o_valid), 128'(0));

        // Skewed fill: eight rows per lane, lane j row r = 0x100*(r+1)+j.
        for (int k = 0; k < 15; k++) begin
            mask = (k < 8) ? COL'((9'd1 << (k + 1)) - 9'd1) : COL'(8'hFF << (k - 7));
            row = '0;
            for (int j = 0; j < COL; j++) row[j*BW +: BW] = BW'(16'h0100 * (wcnt[j] + 1) + j);
            step(1'b0, mask, row, 1'b0);
            if (k == 6) chk("skew_valid_early", 128'(o_valid), 128'(0));
            if (k == 7) begin
                chk("skew_valid_rise", 128'(o_valid), 128'(1));
                for (int j = 0; j < COL; j++) exp_row[j*BW +: BW] = BW'(16'h0100 + j);
                chk("skew_row1", 128'(out), 128'(exp_row));
            end
        end

        // Pop the eight rows.
        step(1'b0, '0, '0, 1'b1);
        for (int j = 0; j < COL; j++) exp_row[j*BW +: BW] = BW'(16'h0200 + j);
        chk("pop_row2", 128'(out), 128'(exp_row));
        for (int i = 0; i < 7; i++) step(1'b0, '0, '0, 1'b1);
        chk("drained_valid", 128'(o_valid), 128'(0));
        chk("drained_out", 128'(out), 128'(0));

        // Fill to full, overflow, drain.
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1'b0, '1, rand_row(), 1'b0);
        chk("full_flags", 128'({o_full, o_ready}), 128'(2'b10));
        step(1'b0, '1, rand_row(), 1'b0);
        chk("ovf_set", 128'(o_ovf), 128'(1));
        for (int i = 0; i < DEPTH; i++) step(1'b0, '0, '0, 1'b1);
        chk("full_drained", 128'(o_valid), 128'(0));

        // Full with concurrent write and pop.
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1'b0, '1, rand_row(), 1'b0);
        step(1'b0, '1, rand_row(), 1'b1);
        chk("wrpop_full", 128'({o_full, o_ovf}), 128'(2'b10));
        for (int i = 0; i < DEPTH; i++) step(1'b0, '0, '0, 1'b1);

        // Random skewed streaming with wrap, mid-stream reset.
        do_reset();
        for (int i = 0; i < 900; i++) begin
            if (i == 450) begin
                step(1'b1, COL'($urandom), rand_row(), 1'($urandom));
                chk("midrst_valid", 128'(o_valid), 128'(0));
            end else begin
                step(1'b0, COL'($urandom), rand_row(), ($urandom_range(0, 99) < 55));
            end
        end
        chk("stream_rows", 128'(wcnt[0] >= 200), 128'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
